// File: rtl/adder_bist.sv
// -----------------------------------------------------------------------------
// adder_bist
//   Built-in self-test engine for a WIDTH-bit combinational adder (WIDTH=1 is
//   the half adder). On a start pulse it walks every operand pair {a,b} in
//   ascending order of the concatenated index. Each pair is held for SETTLE
//   cycles and then checked for one more cycle. The sample is {carry,sum}, and
//   the expected value is a+b. The engine counts mismatches and latches the
//   first failing pair.
//
// Parameters
//   WIDTH   operand width of the adder under test (1..7)
//   SETTLE  cycles operands are held before the CHECK cycle (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   start      one-cycle run request, honoured only in IDLE or DONE
//   dut_a      operand a to the adder (registered)
//   dut_b      operand b to the adder (registered)
//   dut_sum    sum returned by the adder
//   dut_carry  carry-out returned by the adder
//   busy       high while a run is in progress (WAIT or CHECK)
//   done       high once a run has finished; holds until reset or new start
//   pass       done with no mismatches
//   err_count  mismatching vectors in the last run
//   fail_a     a operand of the first mismatch (0 if none)
//   fail_b     b operand of the first mismatch (0 if none)
// -----------------------------------------------------------------------------
module adder_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int IW  = 2 * WIDTH;
  // The settle counter only ever holds SETTLE-1 down to 0.
  localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [WCW-1:0] WC_LOAD = WCW'(SETTLE - 1);
  localparam logic [WCW-1:0] WC_ONE  = WCW'(1);
  localparam logic [IW-1:0]  IDX_ONE = IW'(1);
  localparam logic [IW-1:0]  IDX_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WCW-1:0]   wcnt, wcnt_n;
  logic [WIDTH-1:0] dut_a_n, dut_b_n;
  logic [15:0]      err_n;
  logic [WIDTH-1:0] fail_a_n, fail_b_n;
  logic             busy_n, done_n, pass_n;

  logic [WIDTH:0]   exp_sum;
  logic             mismatch;

  // The reference sum is computed from the registered operands, so the
  // comparison matches the operands the adder has been seeing.
  assign exp_sum  = {1'b0, dut_a} + {1'b0, dut_b};
  assign mismatch = ({dut_carry, dut_sum} != exp_sum);

  // NOTE: every signal written below gets a default first. This prevents a
  // path that leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    wcnt_n   = wcnt;
    err_n    = err_count;
    fail_a_n = fail_a;
    fail_b_n = fail_b;

    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n  = S_WAIT;
          idx_n    = '0;
          wcnt_n   = WC_LOAD;
          err_n    = '0;
          fail_a_n = '0;
          fail_b_n = '0;
        end
      end

      S_WAIT: begin
        if (wcnt == '0) begin
          state_n = S_CHECK;
        end else begin
          wcnt_n = wcnt - WC_ONE;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          err_n = err_count + 16'd1;
          if (err_count == '0) begin
            fail_a_n = dut_a;
            fail_b_n = dut_b;
          end
        end
        if (idx == IDX_MAX) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + IDX_ONE;
          wcnt_n  = WC_LOAD;
          state_n = S_WAIT;
        end
      end

      default: state_n = S_IDLE;
    endcase

    // The operands and the status flags are registered from next-state values.
    // This keeps them aligned with the state and leaves no dut_* -> output path.
    dut_a_n = idx_n[IW-1:WIDTH];
    dut_b_n = idx_n[WIDTH-1:0];
    busy_n  = (state_n == S_WAIT) || (state_n == S_CHECK);
    done_n  = (state_n == S_DONE);
    pass_n  = done_n && (err_n == '0);
  end

  // NOTE: sequential state uses non-blocking assignments. All registers update
  // together on the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      wcnt      <= '0;
      dut_a     <= '0;
      dut_b     <= '0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      wcnt      <= wcnt_n;
      dut_a     <= dut_a_n;
      dut_b     <= dut_b_n;
      err_count <= err_n;
      fail_a    <= fail_a_n;
      fail_b    <= fail_b_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// -----------------------------------------------------------------------------
// tb_adder_bist
//   Four BIST instances share one clock and one reset:
//     0: WIDTH=1, SETTLE=2, half adder with a selectable fault
//     1: WIDTH=4, SETTLE=1, 4-bit adder with a selectable fault
//     2: WIDTH=2, SETTLE=3, adder with a 2-cycle registered output delay
//     3: WIDTH=2, SETTLE=1, the same delayed adder (too short a settle)
//   For each run, the expected error count and first failing pair come from
//   enumerating every operand pair against the chosen fault.
// -----------------------------------------------------------------------------
module tb_adder_bist;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] start;

  always #5 clk = ~clk;

  // Fault modes: 0 none, 1 carry stuck at 0, 2 sum[0] inverted,
  // 3 xor a mask onto {carry,sum} for one chosen vector only.
  int mode_v [4];
  int tgt_v  [4];
  int mask_v [4];

  function automatic logic [7:0] fault_out(int w, int mode, int a, int b,
                                           int tgt, int mask);
    int r;
    r = a + b;
    case (mode)
      1: r = r & ~(1 << w);
      2: r = r ^ 1;
      3: if (((a << w) | b) == tgt) r = r ^ mask;
      default: ;
    endcase
    return 8'(r);
  endfunction

  // ---------------- instance 0 ----------------
  logic       a0, b0, sum0, carry0, busy0, done0, pass0, fa0, fb0;
  logic [15:0] err0;
  logic [7:0] r0;
  always_comb r0 = fault_out(1, mode_v[0], int'(a0), int'(b0), tgt_v[0], mask_v[0]);
  assign sum0   = r0[0];
  assign carry0 = r0[1];

  adder_bist #(.WIDTH(1), .SETTLE(2)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .dut_a(a0), .dut_b(b0),
    .dut_sum(sum0), .dut_carry(carry0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_a(fa0), .fail_b(fb0));

  // ---------------- instance 1 ----------------
  logic [3:0] a1, b1, sum1, fa1, fb1;
  logic       carry1, busy1, done1, pass1;
  logic [15:0] err1;
  logic [7:0] r1;
  always_comb r1 = fault_out(4, mode_v[1], int'(a1), int'(b1), tgt_v[1], mask_v[1]);
  assign sum1   = r1[3:0];
  assign carry1 = r1[4];

  adder_bist #(.WIDTH(4), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .dut_a(a1), .dut_b(b1),
    .dut_sum(sum1), .dut_carry(carry1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_a(fa1), .fail_b(fb1));

  // ---------------- instances 2 and 3: delayed adders ----------------
  logic [1:0] a2, b2, fa2, fb2, a3, b3, fa3, fb3;
  logic       busy2, done2, pass2, busy3, done3, pass3;
  logic [15:0] err2, err3;
  logic [2:0] p1_2, p2_2, p1_3, p2_3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_2 <= '0; p2_2 <= '0; p1_3 <= '0; p2_3 <= '0;
    end else begin
      p1_2 <= {1'b0, a2} + {1'b0, b2};
      p2_2 <= p1_2;
      p1_3 <= {1'b0, a3} + {1'b0, b3};
      p2_3 <= p1_3;
    end
  end

  adder_bist #(.WIDTH(2), .SETTLE(3)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .dut_a(a2), .dut_b(b2),
    .dut_sum(p2_2[1:0]), .dut_carry(p2_2[2]), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_a(fa2), .fail_b(fb2));

  adder_bist #(.WIDTH(2), .SETTLE(1)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .dut_a(a3), .dut_b(b3),
    .dut_sum(p2_3[1:0]), .dut_carry(p2_3[2]), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err3), .fail_a(fa3), .fail_b(fb3));

  // Uniform views for the generic run/check tasks.
  logic        busy_v [4], done_v [4], pass_v [4];
  logic [15:0] err_v  [4];
  logic [7:0]  fa_v   [4], fb_v [4];
  assign busy_v[0] = busy0; assign busy_v[1] = busy1;
  assign busy_v[2] = busy2; assign busy_v[3] = busy3;
  assign done_v[0] = done0; assign done_v[1] = done1;
  assign done_v[2] = done2; assign done_v[3] = done3;
  assign pass_v[0] = pass0; assign pass_v[1] = pass1;
  assign pass_v[2] = pass2; assign pass_v[3] = pass3;
  assign err_v[0]  = err0;  assign err_v[1]  = err1;
  assign err_v[2]  = err2;  assign err_v[3]  = err3;
  assign fa_v[0] = {7'b0, fa0}; assign fa_v[1] = {4'b0, fa1};
  assign fa_v[2] = {6'b0, fa2}; assign fa_v[3] = {6'b0, fa3};
  assign fb_v[0] = {7'b0, fb0}; assign fb_v[1] = {4'b0, fb1};
  assign fb_v[2] = {6'b0, fb2}; assign fb_v[3] = {6'b0, fb3};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string tag, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Pulse start on instance sel and count cycles until done. If inj >= 0,
  // a second start pulse is driven that many cycles into the run; it must
  // have no effect.
  task automatic run(int sel, int exp_cyc, int inj, string tag);
    int cyc;
    @(negedge clk);
    start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
    check({tag, ".busy_after_start"}, busy_v[sel], 1);
    check({tag, ".done_after_start"}, done_v[sel], 0);
    cyc = 0;
    while (!done_v[sel] && cyc < exp_cyc + 20) begin
      start[sel] = (cyc == inj);
      @(negedge clk);
      cyc++;
    end
    start[sel] = 1'b0;
    check({tag, ".run_len"}, cyc, exp_cyc);
    check({tag, ".busy_at_done"}, busy_v[sel], 0);
  endtask

  // Enumerate all operand pairs against the fault to get the expected results.
  task automatic check_result(int sel, int w, string tag);
    int e  = 0;
    int fa = 0;
    int fb = 0;
    for (int i = 0; i < (1 << (2 * w)); i++) begin
      int a = i >> w;
      int b = i & ((1 << w) - 1);
      if (fault_out(w, mode_v[sel], a, b, tgt_v[sel], mask_v[sel]) != 8'(a + b)) begin
        if (e == 0) begin
          fa = a;
          fb = b;
        end
        e++;
      end
    end
    check({tag, ".done"},      done_v[sel], 1);
    check({tag, ".err_count"}, err_v[sel], e);
    check({tag, ".fail_a"},    fa_v[sel], fa);
    check({tag, ".fail_b"},    fb_v[sel], fb);
    check({tag, ".pass"},      pass_v[sel], (e == 0));
  endtask

  task automatic check_cleared(string tag);
    check({tag, ".dut_a"},     a0, 0);
    check({tag, ".dut_b"},     b0, 0);
    check({tag, ".busy"},      busy0, 0);
    check({tag, ".done"},      done0, 0);
    check({tag, ".pass"},      pass0, 0);
    check({tag, ".err_count"}, err0, 0);
    check({tag, ".fail_a"},    fa0, 0);
    check({tag, ".fail_b"},    fb0, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mode_v[i] = 0;
      tgt_v[i]  = 0;
      mask_v[i] = 1;
    end
    start = '0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    check("reset.u1_err", err1, 0);
    rst = 1'b0;

    // Good half adder: 4 vectors x 3 cycles.
    mode_v[0] = 0;
    run(0, 12, -1, "good_ha");
    check_result(0, 1, "good_ha");

    // Carry stuck at 0 fails only at 1+1.
    mode_v[0] = 1;
    run(0, 12, -1, "carry_sa0");
    check_result(0, 1, "carry_sa0");

    // Restart from DONE after a failed run clears the results.
    mode_v[0] = 0;
    run(0, 12, -1, "restart_good");
    check_result(0, 1, "restart_good");

    // 4-bit adder with sum[0] inverted: every vector fails.
    mode_v[1] = 2;
    run(1, 512, -1, "sum0_inv");
    check_result(1, 4, "sum0_inv");

    // Start pulses while busy must not disturb the schedule.
    mode_v[1] = 0;
    run(1, 512, int'($urandom_range(510, 0)), "start_busy");
    check_result(1, 4, "start_busy");

    // Randomized faults.
    for (int k = 0; k < 4; k++) begin
      mode_v[0] = int'($urandom_range(3, 0));
      tgt_v[0]  = int'($urandom_range(3, 0));
      mask_v[0] = int'($urandom_range(3, 1));
      run(0, 12, ($urandom_range(1, 0) == 1) ? int'($urandom_range(10, 0)) : -1,
          $sformatf("rnd_w1_%0d", k));
      check_result(0, 1, $sformatf("rnd_w1_%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      mode_v[1] = int'($urandom_range(3, 0));
      tgt_v[1]  = int'($urandom_range(255, 0));
      mask_v[1] = int'($urandom_range(31, 1));
      run(1, 512, ($urandom_range(1, 0) == 1) ? int'($urandom_range(510, 0)) : -1,
          $sformatf("rnd_w4_%0d", k));
      check_result(1, 4, $sformatf("rnd_w4_%0d", k));
    end

    // Reset two cycles into WAIT of vector 01, then a full rerun.
    mode_v[0] = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun.dut_b", b0, 1);
    check("midrun.busy", busy0, 1);
    rst = 1'b1;
    #1;
    check_cleared("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    run(0, 12, -1, "after_reset");
    check_result(0, 1, "after_reset");

    // A 2-cycle delayed adder passes with SETTLE=3 and fails with SETTLE=1.
    run(2, 16 * 4, -1, "delay_s3");
    check("delay_s3.pass", pass2, 1);
    check("delay_s3.err_count", err2, 0);
    run(3, 16 * 2, -1, "delay_s1");
    check("delay_s1.done", done3, 1);
    check("delay_s1.pass", pass3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
